// File: rtl/sa_latch_rf_wr_ctrl.sv
// Write sequencer for a negedge-capture latch register file: SETUP/OPEN/CLOSE per write.
// Optional even-parity bit on the latch data bus when SA_LRF_PARITY_EN is defined.
module sa_latch_rf_wr_ctrl #(
    parameter int DW    = 32,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             nvdla_core_clk,
    input  logic             nvdla_core_rst,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [AW-1:0]    wr_addr,
    input  logic [DW-1:0]    wr_data,
    input  logic             clr,
`ifdef SA_LRF_PARITY_EN
    output logic [DW:0]      lat_d,
`else
    output logic [DW-1:0]    lat_d,
`endif
    output logic [DEPTH-1:0] lat_en,
    output logic [DEPTH-1:0] entry_vld,
    output logic             wr_done,
    output logic             wr_err,
    output logic             busy
);

`ifdef SA_LRF_PARITY_EN
    localparam int LW = DW + 1;
`else
    localparam int LW = DW;
`endif
    localparam logic [AW:0]       DEPTH_L = (AW+1)'(DEPTH);
    localparam logic [DEPTH-1:0]  ONE     = DEPTH'(1);

    typedef enum logic [1:0] {IDLE, SETUP, OPEN, CLOSE} state_e;

    state_e           state_q, state_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [LW-1:0]    latd_q, latd_d;
    logic [DEPTH-1:0] en_q, en_d;
    logic [DEPTH-1:0] vld_q, vld_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;
    logic             transfer;
    logic             in_range;
    logic [DEPTH-1:0] sel;

    assign wr_ready = (state_q == IDLE) || (state_q == CLOSE);
    assign transfer = wr_valid && wr_ready;
    assign in_range = {1'b0, addr_q} < DEPTH_L;
    assign sel      = in_range ? (ONE << addr_q) : '0;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        latd_d  = latd_q;
        en_d    = '0;
        vld_d   = clr ? '0 : vld_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        if (transfer) begin
            addr_d = wr_addr;
`ifdef SA_LRF_PARITY_EN
            latd_d = {^wr_data, wr_data};
`else
            latd_d = wr_data;
`endif
        end
        unique case (state_q)
            IDLE:  if (transfer) state_d = SETUP;
            SETUP: begin
                state_d = OPEN;
                en_d    = sel;
            end
            // en drops at this edge: the latch captures, so the write is done
            OPEN: begin
                state_d = CLOSE;
                done_d  = 1'b1;
                err_d   = !in_range;
                vld_d   = vld_d | sel;
            end
            CLOSE: state_d = transfer ? SETUP : IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            latd_q  <= '0;
            en_q    <= '0;
            vld_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            latd_q  <= latd_d;
            en_q    <= en_d;
            vld_q   <= vld_d;
            done_q  <= done_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    assign lat_d     = latd_q;
    assign lat_en    = en_q;
    assign entry_vld = vld_q;
    assign wr_done   = done_q;
    assign wr_err    = err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_sa_latch_rf_wr_ctrl.sv
// Bench for sa_latch_rf_wr_ctrl: DEPTH=8 and DEPTH=6 instances on shared inputs.
// Directed table, write-timeline reference model, random traffic, parity cases.
module tb_sa_latch_rf_wr_ctrl;

`ifdef SA_LRF_PARITY_EN
    localparam int LW = 33;
`else
    localparam int LW = 32;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic [2:0]  addr = '0;
    logic [31:0] data = '0;
    logic        clr = 1'b0;

    logic          rdy8, done8, err8, busy8;
    logic [LW-1:0] latd8;
    logic [7:0]    en8, vld8;
    logic          rdy6, done6, err6, busy6;
    logic [LW-1:0] latd6;
    logic [5:0]    en6, vld6;

    always #5 clk = ~clk;

    sa_latch_rf_wr_ctrl #(.DW(32), .DEPTH(8)) u_dut8 (
        .nvdla_core_clk(clk), .nvdla_core_rst(rst),
        .wr_valid(valid), .wr_ready(rdy8),
        .wr_addr(addr), .wr_data(data), .clr(clr),
        .lat_d(latd8), .lat_en(en8), .entry_vld(vld8),
        .wr_done(done8), .wr_err(err8), .busy(busy8)
    );

    sa_latch_rf_wr_ctrl #(.DW(32), .DEPTH(6)) u_dut6 (
        .nvdla_core_clk(clk), .nvdla_core_rst(rst),
        .wr_valid(valid), .wr_ready(rdy6),
        .wr_addr(addr), .wr_data(data), .clr(clr),
        .lat_d(latd6), .lat_en(en6), .entry_vld(vld6),
        .wr_done(done6), .wr_err(err6), .busy(busy6)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        bit        r, v;
        bit [2:0]  a;
        bit [31:0] d;
        bit        c;
        bit [7:0]  en8, vld8;
        bit [5:0]  en6, vld6;
        bit        done, err6, busy, rdy;
        bit [31:0] latd;
    } vec_t;

    vec_t tbl[20];

    function automatic vec_t mk(bit r, bit v, bit [2:0] a, bit [31:0] d,
                                bit c, bit [7:0] e8, bit [7:0] l8,
                                bit [5:0] e6, bit [5:0] l6, bit dn,
                                bit er, bit bz, bit rd, bit [31:0] ld);
        vec_t t;
        t.r = r; t.v = v; t.a = a; t.d = d; t.c = c;
        t.en8 = e8; t.vld8 = l8; t.en6 = e6; t.vld6 = l6;
        t.done = dn; t.err6 = er; t.busy = bz; t.rdy = rd; t.latd = ld;
        return t;
    endfunction

    // Reference: a write is a timeline of edges since its accept.
    // 1 = data set up, 2 = enable open, 3 = captured/done; >3 = no write.
    int         age = 99;
    bit [2:0]   m_addr = '0;
    bit [7:0]   m_vld8 = '0;
    bit [5:0]   m_vld6 = '0;
    bit [LW-1:0] m_latd = '0;

    function automatic bit [LW-1:0] pack(bit [31:0] d);
`ifdef SA_LRF_PARITY_EN
        return {^d, d};
`else
        return d;
`endif
    endfunction

    task automatic cyc(bit r, bit v, bit [2:0] a, bit [31:0] d, bit c);
        bit [7:0] e8;
        bit [5:0] e6;
        bit       dn;
        rst = r; valid = v; addr = a; data = d; clr = c;
        if (r) begin
            age = 99; m_addr = '0; m_vld8 = '0; m_vld6 = '0; m_latd = '0;
        end else begin
            if (c) begin
                m_vld8 = '0;
                m_vld6 = '0;
            end
            if (age == 2) begin
                m_vld8[m_addr] = 1'b1;
                if (m_addr < 6) m_vld6[m_addr] = 1'b1;
            end
            if (v && age >= 3) begin
                age = 1; m_addr = a; m_latd = pack(d);
            end else if (age < 99) begin
                age++;
            end
        end
        @(posedge clk);
        #1;
        e8 = (age == 2) ? (8'd1 << m_addr) : 8'd0;
        e6 = (age == 2 && m_addr < 6) ? (6'd1 << m_addr) : 6'd0;
        dn = (age == 3);
        chk("m_en8", en8, e8);
        chk("m_en6", en6, e6);
        chk("m_vld8", vld8, m_vld8);
        chk("m_vld6", vld6, m_vld6);
        chk("m_done8", done8, dn);
        chk("m_done6", done6, dn);
        chk("m_err8", err8, 0);
        chk("m_err6", err6, dn && m_addr >= 6);
        chk("m_busy", {busy8, busy6}, {2{age <= 3}});
        chk("m_ready", {rdy8, rdy6}, {2{age >= 3}});
        chk("m_latd8", latd8, m_latd);
        chk("m_latd6", latd6, m_latd);
    endtask

    initial begin
        tbl[0]  = mk(1,0,0,0,0,          8'h00,8'h00,6'h00,6'h00,0,0,0,1,0);
        tbl[1]  = mk(0,1,5,32'hDEADBEEF,0,8'h00,8'h00,6'h00,6'h00,0,0,1,0,32'hDEADBEEF);
        tbl[2]  = mk(0,0,0,0,0,          8'h20,8'h00,6'h20,6'h00,0,0,1,0,32'hDEADBEEF);
        tbl[3]  = mk(0,0,0,0,0,          8'h00,8'h20,6'h00,6'h20,1,0,1,1,32'hDEADBEEF);
        tbl[4]  = mk(0,0,0,0,0,          8'h00,8'h20,6'h00,6'h20,0,0,0,1,32'hDEADBEEF);
        tbl[5]  = mk(0,0,0,0,1,          8'h00,8'h00,6'h00,6'h00,0,0,0,1,32'hDEADBEEF);
        tbl[6]  = mk(0,1,7,32'h11,0,     8'h00,8'h00,6'h00,6'h00,0,0,1,0,32'h11);
        tbl[7]  = mk(0,1,0,32'h22,0,     8'h80,8'h00,6'h00,6'h00,0,0,1,0,32'h11);
        tbl[8]  = mk(0,1,0,32'h22,0,     8'h00,8'h80,6'h00,6'h00,1,1,1,1,32'h11);
        tbl[9]  = mk(0,1,0,32'h22,0,     8'h00,8'h80,6'h00,6'h00,0,0,1,0,32'h22);
        tbl[10] = mk(0,0,0,0,0,          8'h01,8'h80,6'h01,6'h00,0,0,1,0,32'h22);
        tbl[11] = mk(0,0,0,0,0,          8'h00,8'h81,6'h00,6'h01,1,0,1,1,32'h22);
        tbl[12] = mk(0,1,3,32'h33,0,     8'h00,8'h81,6'h00,6'h01,0,0,1,0,32'h33);
        tbl[13] = mk(0,0,0,0,0,          8'h08,8'h81,6'h08,6'h01,0,0,1,0,32'h33);
        tbl[14] = mk(0,0,0,0,1,          8'h00,8'h08,6'h00,6'h08,1,0,1,1,32'h33);
        tbl[15] = mk(0,0,0,0,0,          8'h00,8'h08,6'h00,6'h08,0,0,0,1,32'h33);
        tbl[16] = mk(0,1,4,32'h44,0,     8'h00,8'h08,6'h00,6'h08,0,0,1,0,32'h44);
        tbl[17] = mk(0,0,0,0,0,          8'h10,8'h08,6'h10,6'h08,0,0,1,0,32'h44);
        tbl[18] = mk(1,0,0,0,0,          8'h00,8'h00,6'h00,6'h00,0,0,0,1,0);
        tbl[19] = mk(0,0,0,0,0,          8'h00,8'h00,6'h00,6'h00,0,0,0,1,0);

        for (int i = 0; i < 20; i++) begin
            rst = tbl[i].r; valid = tbl[i].v; addr = tbl[i].a;
            data = tbl[i].d; clr = tbl[i].c;
            @(posedge clk);
            #1;
            chk($sformatf("t%0d_en8", i), en8, tbl[i].en8);
            chk($sformatf("t%0d_en6", i), en6, tbl[i].en6);
            chk($sformatf("t%0d_vld8", i), vld8, tbl[i].vld8);
            chk($sformatf("t%0d_vld6", i), vld6, tbl[i].vld6);
            chk($sformatf("t%0d_done", i), {done8, done6}, {2{tbl[i].done}});
            chk($sformatf("t%0d_err", i), {err8, err6}, {1'b0, tbl[i].err6});
            chk($sformatf("t%0d_busy", i), {busy8, busy6}, {2{tbl[i].busy}});
            chk($sformatf("t%0d_rdy", i), {rdy8, rdy6}, {2{tbl[i].rdy}});
            chk($sformatf("t%0d_latd", i), latd8[31:0], tbl[i].latd);
        end

        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 600; i++) begin
            cyc($urandom_range(0, 49) == 0,
                $urandom_range(0, 9) < 6,
                3'($urandom_range(0, 7)),
                $urandom,
                $urandom_range(0, 9) == 0);
        end

`ifdef SA_LRF_PARITY_EN
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 1, 32'h7, 0);
        chk("par7", latd8[32], 1'b1);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 1, 2, 32'h3, 0);
        chk("par3", latd8[32], 1'b0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
